pdm_capture: RTL and testbench



---
 rtl/pdm_capture_if.sv | 22 ++
 rtl/pdm_capture.sv | 174 +++++++++++++++++
 tb/tb_pdm_capture.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_capture_if.sv
// pdm_capture_if: single-cycle RAM write port
// driven by the PDM capture engine.
interface pdm_capture_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 12
);
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_data;

  modport master (
    output ram_wr,
    output ram_addr,
    output ram_data
  );

  modport slave (
    input ram_wr,
    input ram_addr,
    input ram_data
  );
endinterface

// File: rtl/pdm_capture.sv
// pdm_capture: mono/stereo PDM mic capture into a sample RAM.
// Define PDM_CAPTURE_CONT_EN to enable continuous ring-buffer mode.
module pdm_capture #(
  parameter int CLK_DIV  = 25,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int CHANNELS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic stop,
  input  logic mode,
  input  logic micData,
  output logic mic_clk,
  output logic busy,
  output logic done,
  output logic wrap,
  pdm_capture_if.master ram
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(WORD_W - 1);
  localparam bit STEREO = (CHANNELS == 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAP,
    S_WR2,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [DW-1:0]     r_div;
  logic [BW-1:0]     r_bit;
  logic              r_mclk;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;
  logic [WORD_W-1:0] r_sr0;
  logic [WORD_W-1:0] r_sr1;
  logic              r_busy;
  logic              r_done;

  logic w_tick;
  logic w_s0;
  logic w_s1;
  logic w_last;
  logic w_full;
  logic w_run;
  logic w_start;
  logic w_cont;
  logic w_wrap;

  assign w_tick  = (r_div == DIV_MAX);
  assign w_s0    = w_tick & r_mclk;
  assign w_s1    = w_tick & ~r_mclk & STEREO;
  assign w_last  = (r_bit == BIT_MAX);
  assign w_full  = (r_addr == '1);
  assign w_run   = (r_state == S_CAP) |
                   (r_state == S_WR2);
  assign w_start = ~w_run & enable & ~stop;
  assign w_wrap  = w_run & ~stop & r_wr &
                   w_full & w_cont;

`ifdef PDM_CAPTURE_CONT_EN
  logic r_mode;
  logic r_wrap;

  // Latch ring mode at start; pulse wrap as addr returns to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (w_start) r_mode <= mode;
      r_wrap <= w_wrap;
    end
  end

  assign w_cont = r_mode;
  assign wrap   = r_wrap;
`else
  logic w_unused;
  assign w_unused = mode ^ w_wrap;
  assign w_cont   = 1'b0;
  assign wrap     = 1'b0;
`endif

  // Capture FSM: divider, sampling, packing and RAM writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_mclk  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_sr0   <= '0;
      r_sr1   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_wr <= 1'b0;
          if (w_start) begin
            r_state <= S_CAP;
            r_div   <= '0;
            r_mclk  <= 1'b0;
            r_bit   <= '0;
            r_addr  <= '0;
            r_sr0   <= '0;
            r_sr1   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_CAP, S_WR2: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_mclk  <= 1'b0;
            r_div   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) r_mclk <= ~r_mclk;
            if (w_s1) begin
              r_sr1 <= {r_sr1[WORD_W-2:0], micData};
            end
            r_wr <= 1'b0;
            if (r_wr) r_addr <= r_addr + 1'b1;
            if (r_state == S_WR2) begin
              r_wr    <= 1'b1;
              r_data  <= r_sr1;
              r_state <= S_CAP;
            end else if (w_s0) begin
              r_sr0 <= {r_sr0[WORD_W-2:0], micData};
              if (w_last) begin
                r_bit  <= '0;
                r_wr   <= 1'b1;
                r_data <= {r_sr0[WORD_W-2:0], micData};
                if (STEREO) r_state <= S_WR2;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
            if (r_wr && w_full && !w_cont) begin
              r_state <= S_DONE;
              r_wr    <= 1'b0;
              r_mclk  <= 1'b0;
              r_div   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mic_clk      = r_mclk;
  assign busy         = r_busy;
  assign done         = r_done;
  assign ram.ram_wr   = r_wr;
  assign ram.ram_addr = r_addr;
  assign ram.ram_data = r_data;

endmodule

// File: tb/tb_pdm_capture.sv
// tb_pdm_capture: directed bench for mono and stereo
// pdm_capture instances (CLK_DIV=2, WORD_W=8, ADDR_W=2).
module tb_pdm_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic m_en = 1'b0;
  logic m_stop = 1'b0;
  logic m_mode = 1'b0;
  logic m_mic = 1'b0;
  wire  m_mclk, m_busy, m_done, m_wrap;

  logic s_en = 1'b0;
  logic s_stop = 1'b0;
  logic s_mode = 1'b0;
  wire  s_mic;
  wire  s_mclk, s_busy, s_done, s_wrap;

  assign s_mic = ~s_mclk;

  pdm_capture_if #(.WORD_W(8), .ADDR_W(2)) mif ();
  pdm_capture_if #(.WORD_W(8), .ADDR_W(2)) sif ();

  pdm_capture #(
    .CLK_DIV(2), .WORD_W(8),
    .ADDR_W(2), .CHANNELS(1)
  ) u_mono (
    .clk(clk), .rst(rst),
    .enable(m_en), .stop(m_stop),
    .mode(m_mode), .micData(m_mic),
    .mic_clk(m_mclk), .busy(m_busy),
    .done(m_done), .wrap(m_wrap),
    .ram(mif)
  );

  pdm_capture #(
    .CLK_DIV(2), .WORD_W(8),
    .ADDR_W(2), .CHANNELS(2)
  ) u_ster (
    .clk(clk), .rst(rst),
    .enable(s_en), .stop(s_stop),
    .mode(s_mode), .micData(s_mic),
    .mic_clk(s_mclk), .busy(s_busy),
    .done(s_done), .wrap(s_wrap),
    .ram(sif)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_mono(input int ncyc,
                          input int stop_at,
                          input bit patt,
                          input logic [7:0] exp_d,
                          output int nwr,
                          output int nwrap);
    logic [7:0] pat;
    int k;
    pat = 8'b1011_0010;
    nwr = 0;
    nwrap = 0;
    m_en = 1'b1;
    tick();
    m_en = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      m_stop = (cyc == stop_at);
      k = (cyc + 1) / 4;
      if (patt && ((cyc + 1) % 4 == 0) && k <= 8)
        m_mic = pat[8-k];
      if (mif.ram_wr) begin
        check("m_addr", 32'(mif.ram_addr), 32'(nwr % 4));
        check("m_data", 32'(mif.ram_data), 32'(exp_d));
        check("m_wcyc", 32'(cyc), 32'(32 * (nwr + 1)));
        nwr++;
      end
      if (m_wrap) nwrap++;
      tick();
    end
    m_stop = 1'b0;
  endtask

  int nwr;
  int nwrap;
  int mc_or;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_mic = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_mclk", 32'(m_mclk), 0);
    check("rst_wr", 32'(mif.ram_wr), 0);
    check("rst_addr", 32'(mif.ram_addr), 0);
    check("rst_data", 32'(mif.ram_data), 0);
    check("rst_busy", 32'(m_busy), 0);
    check("rst_done", 32'(m_done), 0);
    check("rst_wrap", 32'(m_wrap), 0);
    check("rst_s_wr", 32'(sif.ram_wr), 0);
    check("rst_s_busy", 32'(s_busy), 0);
    rst = 1'b0;
    mc_or = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_mclk || s_mclk) mc_or = 1;
      tick();
    end
    check("idle_mclk", 32'(mc_or), 0);

    run_mono(140, -1, 1'b0, 8'hFF, nwr, nwrap);
    check("os_nwr", 32'(nwr), 4);
    check("os_done", 32'(m_done), 1);
    check("os_busy", 32'(m_busy), 0);
    check("os_mclk", 32'(m_mclk), 0);
    check("os_wrap", 32'(nwrap), 0);

    run_mono(34, 33, 1'b1, 8'hB2, nwr, nwrap);
    check("bo_nwr", 32'(nwr), 1);
    check("bo_busy", 32'(m_busy), 0);
    check("bo_done", 32'(m_done), 0);

    m_en = 1'b1;
    m_stop = 1'b1;
    tick();
    m_en = 1'b0;
    m_stop = 1'b0;
    tick();
    check("se_busy", 32'(m_busy), 0);

    m_mic = 1'b1;
    run_mono(240, 40, 1'b0, 8'hFF, nwr, nwrap);
    check("st_nwr", 32'(nwr), 1);
    check("st_busy", 32'(m_busy), 0);
    check("st_mclk", 32'(m_mclk), 0);

    run_mono(34, -1, 1'b0, 8'hFF, nwr, nwrap);
    check("rs_nwr", 32'(nwr), 1);
    check("rs_busy", 32'(m_busy), 1);
    m_stop = 1'b1;
    tick();
    m_stop = 1'b0;
    check("rs_stop", 32'(m_busy), 0);

    m_mode = 1'b1;
    run_mono(170, -1, 1'b0, 8'hFF, nwr, nwrap);
    m_mode = 1'b0;
`ifdef PDM_CAPTURE_CONT_EN
    check("ct_nwr", 32'(nwr), 5);
    check("ct_wrap", 32'(nwrap), 1);
    check("ct_done", 32'(m_done), 0);
    check("ct_busy", 32'(m_busy), 1);
`else
    check("ct_nwr", 32'(nwr), 4);
    check("ct_wrap", 32'(nwrap), 0);
    check("ct_done", 32'(m_done), 1);
    check("ct_busy", 32'(m_busy), 0);
`endif
    m_stop = 1'b1;
    tick();
    m_stop = 1'b0;
    tick();
    check("ct_stop", 32'(m_busy), 0);

    m_en = 1'b1;
    tick();
    m_en = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    tick();
    check("mr_busy", 32'(m_busy), 0);
    check("mr_mclk", 32'(m_mclk), 0);
    check("mr_addr", 32'(mif.ram_addr), 0);
    check("mr_data", 32'(mif.ram_data), 0);
    rst = 1'b0;
    tick();

    nwr = 0;
    s_en = 1'b1;
    tick();
    s_en = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (sif.ram_wr) begin
        check("s_addr", 32'(sif.ram_addr), 32'(nwr));
        check("s_data", 32'(sif.ram_data),
              (nwr % 2) ? 32'hFF : 32'h00);
        check("s_wcyc", 32'(cyc),
              32'(32 * (nwr / 2 + 1) + nwr % 2));
        nwr++;
      end
      tick();
    end
    check("s_nwr", 32'(nwr), 4);
    check("s_done", 32'(s_done), 1);
    check("s_busy", 32'(s_busy), 0);
    check("s_mclk", 32'(s_mclk), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
